// File: rtl/inst_fetch.sv
// Instruction-fetch controller: issues one word read per instruction on an SRAM-like bus
// and captures the returned word into the registered IF/ID slot.
module inst_fetch #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_start,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_en,
  input  logic             flush,
  input  logic             id_allowin,
  output logic             inst_req,
  output logic             inst_wr,
  output logic [1:0]       inst_size,
  output logic [WIDTH-1:0] inst_addr,
  output logic [WIDTH-1:0] inst_wdata,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_inst
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

  state_t           state;
  logic [WIDTH-1:0] req_pc;
  logic             space;
  logic             load;

  // A request is only issued when the slot can take the answer, so WAIT never stalls on the slot.
  assign space      = !if_valid || id_allowin;
  assign inst_req   = (state == REQ) && space && !flush;
  assign pc_en      = inst_req && inst_addr_ok;
  assign load       = (state == WAIT) && inst_data_ok && !flush;

  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_wdata = '0;
  assign inst_addr  = {pc[WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      req_pc   <= '0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_start) state <= REQ;
        end
        REQ: begin
          if (pc_en) begin
            req_pc <= pc;
            state  <= WAIT;
          end
        end
        WAIT: begin
          // A flush with the response in hand just drops it; otherwise the response is still owed.
          if (inst_data_ok)  state <= REQ;
          else if (flush)    state <= DISCARD;
        end
        DISCARD: begin
          if (inst_data_ok) state <= REQ;
        end
        default: state <= IDLE;
      endcase

      if (flush) begin
        if_valid <= 1'b0;
      end else if (load) begin
        if_valid <= 1'b1;
        if_pc    <= req_pc;
        if_inst  <= inst_rdata;
      end else if (if_valid && id_allowin) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed boot/fetch/backpressure/flush/reset scenarios followed by
// random traffic, all compared against a transaction-level model of the fetch unit.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_start;
  logic [31:0] pc;
  logic        pc_en;
  logic        flush;
  logic        id_allowin;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  inst_fetch #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .pc_start(pc_start), .pc(pc), .pc_en(pc_en), .flush(flush),
    .id_allowin(id_allowin), .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .if_valid(if_valid),
    .if_pc(if_pc), .if_inst(if_inst)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: fetch unit seen as "started" flag, a list of outstanding reads
  // (each possibly cancelled by a redirect), the IF/ID slot, and the external PC register.
  bit          pstart;
  bit          active;
  logic [31:0] m_pc;
  bit          sv;
  logic [31:0] spc;
  logic [31:0] sinst;
  logic [31:0] pend_pc[$];
  bit          pend_kill[$];

  task automatic model_reset();
    pstart = 1'b0;
    active = 1'b0;
    m_pc   = 32'hbfc00000;
    sv     = 1'b0;
    spc    = '0;
    sinst  = '0;
    pend_pc.delete();
    pend_kill.delete();
  endtask

  task automatic step(input bit f, input bit a, input bit aok, input bit dok_in,
                      input logic [31:0] rd, input logic [31:0] tgt);
    bit er;
    bit hs;
    bit dok;
    @(posedge clk);
    #1;
    dok          = dok_in && (pend_pc.size() != 0);
    pc           = m_pc;
    pc_start     = pstart;
    flush        = f;
    id_allowin   = a;
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = rd;
    #3;
    er = active && (pend_pc.size() == 0) && (!sv || a) && !f;
    hs = er && aok;
    chk("inst_req", {31'b0, inst_req}, {31'b0, er});
    chk("pc_en", {31'b0, pc_en}, {31'b0, hs});
    chk("inst_addr", inst_addr, {m_pc[31:2], 2'b00});
    chk("if_valid", {31'b0, if_valid}, {31'b0, sv});
    chk("if_pc", if_pc, spc);
    chk("if_inst", if_inst, sinst);
    chk("bus_const", {inst_wdata[29:0], inst_size}, {30'b0, 2'b10} | {31'b0, inst_wr});
    // Effects of the coming edge.
    if (sv && a) sv = 1'b0;
    if (dok) begin
      if (!pend_kill[0] && !f) begin
        sv    = 1'b1;
        spc   = pend_pc[0];
        sinst = rd;
      end
      void'(pend_pc.pop_front());
      void'(pend_kill.pop_front());
    end else if (f && pend_pc.size() != 0) begin
      pend_kill[0] = 1'b1;
    end
    if (f) sv = 1'b0;
    if (hs) begin
      pend_pc.push_back(m_pc);
      pend_kill.push_back(1'b0);
    end
    if (pstart) active = 1'b1;
    if (f)       m_pc = tgt;
    else if (hs) m_pc = m_pc + 32'd4;
  endtask

  initial begin
    model_reset();
    rst = 1'b0; pc_start = 1'b0; pc = 32'hbfc00000; flush = 1'b0; id_allowin = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;

    // Boot: three cycles in reset, outputs all low.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("rst_req", {31'b0, inst_req}, 32'd0);
      chk("rst_pc_en", {31'b0, pc_en}, 32'd0);
      chk("rst_slot", {31'b0, if_valid} | if_pc | if_inst, 32'd0);
    end
    #1 rst = 1'b1;
    step(0, 1, 0, 0, 0, 0);
    pstart = 1'b1;
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("boot_addr", inst_addr, 32'hbfc00000);
    chk("boot_req", {31'b0, inst_req}, 32'd1);

    // Single fetch: accept in N, data in N+2.
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 32'h24080001, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("fetch_pc", if_pc, 32'hbfc00000);
    chk("fetch_inst", if_inst, 32'h24080001);
    chk("fetch_addr", inst_addr, 32'hbfc00004);

    // Backpressure: slot held for 4 more cycles, then released with a new request.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 32'h11112222, 0);
    step(0, 1, 0, 0, 0, 0);

    // Flush while waiting: late data must be discarded.
    step(0, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 32'hbfc00380);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 32'hdeadbeef, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("flush_addr", inst_addr, 32'hbfc00380);
    chk("flush_valid", {31'b0, if_valid}, 32'd0);

    // Flush coincident with data_ok.
    step(0, 1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 32'hcafef00d, 32'hbfc01000);
    step(0, 1, 0, 0, 0, 0);
    chk("coinc_req", {31'b0, inst_req}, 32'd1);

    // Get a real instruction into the slot, then reset asynchronously while a read is pending.
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 32'h8c020010, 0);
    step(0, 1, 1, 0, 0, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_req", {31'b0, inst_req}, 32'd0);
    chk("async_pc_en", {31'b0, pc_en}, 32'd0);
    chk("async_slot", {31'b0, if_valid} | if_pc | if_inst, 32'd0);
    model_reset();
    pc_start = 1'b0; flush = 1'b0; inst_data_ok = 1'b0; inst_addr_ok = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    pstart = 1'b1;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0), $urandom_range(0, 1),
           ($urandom_range(0, 2) == 0), $urandom, 32'hbfc00000 | $urandom_range(0, 16'hffff));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
